// File: rtl/regfile_2w_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2w_bypass_sb
// Brief    : 2-write/2-read register file with write-to-read bypass and a
//            per-register pending scoreboard for load-use stalls.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2w_bypass_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] read_addr1,
  input  logic [ADDRESS_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0]    read_data1,
  output logic [DATA_WIDTH-1:0]    read_data2,
  output logic                     read_busy1,
  output logic                     read_busy2,
  input  logic                     write_en_a,
  input  logic [ADDRESS_WIDTH-1:0] write_addr_a,
  input  logic [DATA_WIDTH-1:0]    write_data_a,
  input  logic                     write_en_b,
  input  logic [ADDRESS_WIDTH-1:0] write_addr_b,
  input  logic [DATA_WIDTH-1:0]    write_data_b,
  input  logic                     reserve_en,
  input  logic [ADDRESS_WIDTH-1:0] reserve_addr,
  output logic [ADDRESS_WIDTH:0]   pending_count
);

  localparam int c_depth = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]  r_regs [c_depth];
  logic [c_depth-1:0]     r_pending;
  logic [c_depth-1:0]     w_pending_next;
  logic [ADDRESS_WIDTH:0] r_count;
  logic [ADDRESS_WIDTH:0] w_count_next;

  // Port A is checked first so it wins a same-address collision with port B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_depth; i++) begin
        if ((ZERO_REG == 0) || (i != 0)) begin
          if (write_en_a && (write_addr_a == ADDRESS_WIDTH'(i))) begin
            r_regs[i] <= write_data_a;
          end else if (write_en_b && (write_addr_b == ADDRESS_WIDTH'(i))) begin
            r_regs[i] <= write_data_b;
          end
        end
      end
    end
  end

  // Reserve is applied after the clear so a new load outranks its own return.
  always_comb begin
    w_pending_next = r_pending;
    if (write_en_b) begin
      w_pending_next[write_addr_b] = 1'b0;
    end
    if (reserve_en) begin
      w_pending_next[reserve_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_pending_next[0] = 1'b0;
    end
    w_count_next = '0;
    for (int i = 0; i < c_depth; i++) begin
      w_count_next = w_count_next + {{ADDRESS_WIDTH{1'b0}}, w_pending_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
    end
  end

  generate
    for (genvar gp = 0; gp < 2; gp++) begin : g_rd
      logic [ADDRESS_WIDTH-1:0] w_addr;
      logic [DATA_WIDTH-1:0]    w_data;
      logic                     w_busy;

      assign w_addr = (gp == 0) ? read_addr1 : read_addr2;

      always_comb begin
        w_data = r_regs[w_addr];
        w_busy = r_pending[w_addr];
        if (BYPASS != 0) begin
          if (write_en_a && (write_addr_a == w_addr)) begin
            w_data = write_data_a;
          end else if (write_en_b && (write_addr_b == w_addr)) begin
            w_data = write_data_b;
          end
          if (write_en_b && (write_addr_b == w_addr)) begin
            w_busy = 1'b0;
          end
        end
        if ((ZERO_REG != 0) && (w_addr == '0)) begin
          w_data = '0;
          w_busy = 1'b0;
        end
      end
    end
  endgenerate

  assign read_data1    = g_rd[0].w_data;
  assign read_data2    = g_rd[1].w_data;
  assign read_busy1    = g_rd[0].w_busy;
  assign read_busy2    = g_rd[1].w_busy;
  assign pending_count = r_count;

endmodule
`default_nettype wire
